note_tone_gen: RTL and testbench

Square-wave tone generator that sits directly downstream of the music processor and drives the speaker pin. It accepts one note at a time over a valid/ready handshake: a half-period in clock cycles plus a duration in milliseconds. It plays the note as a 50% duty square wave, then inserts a fixed silent articulation gap, and signals completion. The millisecond time base is derived from the same ticks-per-millisecond value the top level already supplies.

---
 rtl/note_tone_gen_if.sv | 27 ++
 rtl/note_tone_gen.sv | 114 +++++++++++
 tb/tb_note_tone_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/note_tone_gen_if.sv
// Note request / speaker bus between the music processor and note_tone_gen.
// Master drives the note request and stop; slave returns handshake, status and sound.
`timescale 1ns/1ps
interface note_tone_gen_if #(
    parameter int PERIOD_W = 16,
    parameter int MS_W     = 12
);
    logic [15:0]         ticks_per_milli;
    logic                note_valid;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_period;
    logic [MS_W-1:0]     note_ms;
    logic                stop;
    logic                sound;
    logic                busy;
    logic                note_done;

    modport master (
        output ticks_per_milli, note_valid, note_period, note_ms, stop,
        input  note_ready, sound, busy, note_done
    );

    modport slave (
        input  ticks_per_milli, note_valid, note_period, note_ms, stop,
        output note_ready, sound, busy, note_done
    );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave note player: plays one accepted note for note_ms milliseconds,
// then a fixed silent gap, then pulses note_done for one cycle.
`timescale 1ns/1ps
module note_tone_gen #(
    parameter int GAP_MS   = 1,
    parameter int PERIOD_W = 16,
    parameter int MS_W     = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    note_tone_gen_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [MS_W-1:0]     GAP_LOAD = MS_W'(GAP_MS);
    localparam logic [MS_W-1:0]     MS_ONE   = MS_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);

    logic [1:0]          r_state;
    logic [15:0]         r_tick;
    logic [15:0]         r_tpm;
    logic [MS_W-1:0]     r_ms;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_half;
    logic                r_sound;
    logic                r_done;

    logic [15:0]         w_tpm_in;
    logic                w_strobe;
    logic                w_last;

    assign w_tpm_in = (bus.ticks_per_milli == 16'd0) ? 16'd1 : bus.ticks_per_milli;
    assign w_strobe = (r_tick == r_tpm - 16'd1);
    // Final strobe of the current PLAY or GAP phase.
    assign w_last   = w_strobe && (r_ms == MS_ONE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.stop) begin
            r_state  <= S_IDLE;
            r_tick   <= 16'd0;
            r_tpm    <= 16'd0;
            r_ms     <= '0;
            r_period <= '0;
            r_half   <= '0;
            r_sound  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.note_valid) begin
                        r_tpm    <= w_tpm_in;
                        r_period <= bus.note_period;
                        r_tick   <= 16'd0;
                        r_half   <= (bus.note_period == '0) ? '0 : bus.note_period - P_ONE;
                        if (bus.note_ms != '0) begin
                            r_state <= S_PLAY;
                            r_ms    <= bus.note_ms;
                            r_sound <= (bus.note_period != '0);
                        end else if (GAP_MS != 0) begin
                            r_state <= S_GAP;
                            r_ms    <= GAP_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    r_tick <= w_strobe ? 16'd0 : r_tick + 16'd1;
                    if (w_strobe) r_ms <= r_ms - MS_ONE;
                    if (w_last) begin
                        r_sound <= 1'b0;
                        r_half  <= '0;
                        if (GAP_MS != 0) begin
                            r_state <= S_GAP;
                            r_ms    <= GAP_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (r_period != '0) begin
                        if (r_half == '0) begin
                            r_sound <= ~r_sound;
                            r_half  <= r_period - P_ONE;
                        end else begin
                            r_half  <= r_half - P_ONE;
                        end
                    end
                end

                S_GAP: begin
                    r_tick <= w_strobe ? 16'd0 : r_tick + 16'd1;
                    if (w_strobe) r_ms <= r_ms - MS_ONE;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sound      = r_sound;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.note_ready = (r_state == S_IDLE);
    assign bus.note_done  = r_done;
endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench: two instances (GAP_MS=1 and GAP_MS=0) compared cycle by
// cycle against an arithmetic timeline model of a single note.
`timescale 1ns/1ps
module tb_note_tone_gen;
    logic        clk;
    logic        rst_n;
    logic [15:0] tpm;
    logic [15:0] per;
    logic [11:0] ms;
    logic        stp;
    logic        v1;
    logic        v0;

    int n_chk = 0;
    int n_err = 0;

    note_tone_gen_if #(.PERIOD_W(16), .MS_W(12)) if1 ();
    note_tone_gen_if #(.PERIOD_W(16), .MS_W(12)) if0 ();

    assign if1.ticks_per_milli = tpm;
    assign if1.note_period     = per;
    assign if1.note_ms         = ms;
    assign if1.stop            = stp;
    assign if1.note_valid      = v1;
    assign if0.ticks_per_milli = tpm;
    assign if0.note_period     = per;
    assign if0.note_ms         = ms;
    assign if0.stop            = stp;
    assign if0.note_valid      = v0;

    note_tone_gen #(.GAP_MS(1), .PERIOD_W(16), .MS_W(12)) u_dut_gap1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    note_tone_gen #(.GAP_MS(0), .PERIOD_W(16), .MS_W(12)) u_dut_gap0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Observed vector {sound, busy, note_done, note_ready} of the chosen instance.
    function automatic logic [3:0] obs(input int g);
        if (g != 0) return {if1.sound, if1.busy, if1.note_done, if1.note_ready};
        return {if0.sound, if0.busy, if0.note_done, if0.note_ready};
    endfunction

    // Expected vector k cycles after the accept edge (k=1 is the first PLAY cycle).
    function automatic logic [3:0] model(input int k, input int t, input int p,
                                         input int n, input int gap);
        int   play_len;
        int   total;
        logic s;
        logic b;
        logic d;
        play_len = n * t;
        total    = (n + gap) * t;
        b = (k <= total);
        d = (k == total + 1);
        s = (p != 0) && (k <= play_len) && ((((k - 1) / p) % 2) == 0);
        return {s, b, d, ~b};
    endfunction

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        n_chk++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed {snd,busy,done,rdy}=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one note on instance g and check every cycle through done+1.
    task automatic run_note(input string name, input int g, input int t_in, input int p,
                            input int n, input int new_tpm, input int change_k);
        int t;
        int gap;
        int total;
        t     = (t_in == 0) ? 1 : t_in;
        gap   = (g != 0) ? 1 : 0;
        total = (n + gap) * t;
        tpm   = 16'(t_in);
        per   = 16'(p);
        ms    = 12'(n);
        if (g != 0) v1 = 1'b1; else v0 = 1'b1;
        step();
        v1 = 1'b0;
        v0 = 1'b0;
        for (int k = 1; k <= total + 2; k++) begin
            if (k == change_k) tpm = 16'(new_tpm);
            check($sformatf("%s k=%0d", name, k), obs(g), model(k, t, p, n, gap));
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tpm   = 16'd0;
        per   = 16'd0;
        ms    = 12'd0;
        stp   = 1'b0;
        v1    = 1'b0;
        v0    = 1'b0;
        step();
        step();
        check("reset_gap1", obs(1), 4'b0001);
        check("reset_gap0", obs(0), 4'b0001);
        rst_n = 1'b1;
        step();

        // Basic note: HHHLLL... for 20 cycles, 10 silent, done at +31.
        run_note("basic", 1, 10, 3, 2, -1, 0);

        // Back-to-back on the GAP_MS=0 instance, second accept in the done cycle.
        tpm = 16'd4;
        per = 16'd2;
        ms  = 12'd1;
        v0  = 1'b1;
        step();
        per = 16'd5;
        for (int k = 1; k <= 11; k++) begin
            if (k == 6) v0 = 1'b0;
            check($sformatf("b2b k=%0d", k), obs(0),
                  (k <= 5) ? model(k, 4, 2, 1, 0) : model(k - 5, 4, 5, 1, 0));
            step();
        end

        // Rest and zero-duration notes.
        run_note("rest", 1, 10, 0, 3, -1, 0);
        run_note("zero_ms", 1, 10, 4, 0, -1, 0);
        run_note("zero_ms_nogap", 0, 10, 4, 0, -1, 0);

        // ticks_per_milli=0 acts as 1; a mid-note change is ignored.
        run_note("tpm0", 1, 0, 2, 3, -1, 0);
        run_note("tpm_change", 1, 10, 3, 2, 3, 5);

        // Abort 7 cycles into a note.
        tpm = 16'd10;
        per = 16'd3;
        ms  = 12'd5;
        v1  = 1'b1;
        step();
        v1 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("abort k=%0d", k), obs(1), model(k, 10, 3, 5, 1));
            if (k == 7) stp = 1'b1;
            step();
        end
        stp = 1'b0;
        check("abort_next", obs(1), 4'b0001);
        stp = 1'b1;
        v1  = 1'b1;
        step();
        check("stop_blocks_accept", obs(1), 4'b0001);
        stp = 1'b0;
        v1  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("after_abort k=%0d", k), obs(1), 4'b0001);
            step();
        end

        // Reset asserted for one edge in the middle of the GAP.
        tpm = 16'd10;
        per = 16'd3;
        ms  = 12'd2;
        v1  = 1'b1;
        step();
        v1 = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            check($sformatf("pre_reset k=%0d", k), obs(1), model(k, 10, 3, 2, 1));
            if (k == 25) rst_n = 1'b0;
            step();
        end
        rst_n = 1'b1;
        check("mid_gap_reset_gap1", obs(1), 4'b0001);
        check("mid_gap_reset_gap0", obs(0), 4'b0001);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("after_reset k=%0d", k), obs(1), 4'b0001);
            step();
        end
        run_note("after_reset_note", 1, 3, 2, 2, -1, 0);

        // Randomized notes on both instances.
        for (int i = 0; i < 16; i++) begin
            int g;
            int t;
            int p;
            int n;
            g = int'($urandom_range(0, 1));
            t = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 5));
            n = int'($urandom_range(0, 4));
            run_note($sformatf("rand%0d g=%0d t=%0d p=%0d n=%0d", i, g, t, p, n), g, t, p, n, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
